// File: rtl/mfm_sync_sequencer.sv
// Sync-word acquisition sequencer: arms the MFM sync detector, qualifies a run of
// correctly spaced detections and reports found / timeout / abort.
module mfm_sync_sequencer #(
    parameter logic [15:0] SPACING_MIN = 16'd496,
    parameter logic [15:0] SPACING_MAX = 16'd528
) (
    input  logic        MASTER_CLK,
    input  logic        RESET,
    input  logic        CLKEN,
    input  logic        START,
    input  logic        ABORT,
    input  logic [15:0] SYNC_WORD_CFG,
    input  logic [15:0] MASK_CFG,
    input  logic [3:0]  SYNC_COUNT_CFG,
    input  logic [23:0] TIMEOUT_CFG,
    input  logic        SYNC_WORD_DETECTED,
    output logic [15:0] SYNC_WORD_OUT,
    output logic [15:0] MASK_OUT,
    output logic        BUSY,
    output logic        SYNC_FOUND,
    output logic        DONE,
    output logic        TIMED_OUT,
    output logic [3:0]  MATCH_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_TRACK, S_FOUND, S_TIMEOUT
    } state_t;

    state_t      state, state_n;
    logic        det_q, det_ev;
    logic [15:0] gap, gap_n, gap_inc;
    logic [23:0] tmo, tmo_inc, tmo_cfg;
    logic [3:0]  req, cnt_n;
    logic        in_window, tmo_hit, arm, busy_s;

    assign det_ev    = CLKEN & SYNC_WORD_DETECTED & ~det_q;
    // gap_inc is the tick distance including the current tick
    assign gap_inc   = (gap == 16'hFFFF) ? gap : gap + 16'd1;
    assign in_window = (gap_inc >= SPACING_MIN) && (gap_inc <= SPACING_MAX);
    assign tmo_inc   = tmo + 24'd1;
    assign tmo_hit   = CLKEN && (tmo_cfg != 24'd0) && (tmo_inc == tmo_cfg);
    assign busy_s    = (state == S_ARMED) || (state == S_TRACK);
    assign arm       = START && !busy_s;

    always_comb begin
        state_n = state;
        cnt_n   = MATCH_COUNT;
        gap_n   = gap;
        case (state)
            S_ARMED: begin
                if (ABORT) begin
                    state_n = S_IDLE;
                    cnt_n   = 4'd0;
                end else begin
                    if (det_ev) begin
                        cnt_n   = 4'd1;
                        gap_n   = 16'd0;
                        state_n = (req == 4'd1) ? S_FOUND : S_TRACK;
                    end
                    if (tmo_hit && state_n != S_FOUND) state_n = S_TIMEOUT;
                end
            end
            S_TRACK: begin
                if (ABORT) begin
                    state_n = S_IDLE;
                    cnt_n   = 4'd0;
                    gap_n   = 16'd0;
                end else if (CLKEN) begin
                    if (det_ev && in_window) begin
                        cnt_n = MATCH_COUNT + 4'd1;
                        gap_n = 16'd0;
                        if (cnt_n == req) state_n = S_FOUND;
                    end else if (det_ev) begin
                        cnt_n = 4'd1;
                        gap_n = 16'd0;
                    end else if (gap_inc > SPACING_MAX) begin
                        cnt_n   = 4'd0;
                        gap_n   = 16'd0;
                        state_n = S_ARMED;
                    end else begin
                        gap_n = gap_inc;
                    end
                    // a final match on the timeout tick still wins
                    if (tmo_hit && state_n != S_FOUND) state_n = S_TIMEOUT;
                end
            end
            default: begin
                if (arm) begin
                    state_n = S_ARMED;
                    cnt_n   = 4'd0;
                    gap_n   = 16'd0;
                end
            end
        endcase
    end

    always_ff @(posedge MASTER_CLK) begin
        if (RESET) begin
            state         <= S_IDLE;
            MATCH_COUNT   <= 4'd0;
            gap           <= 16'd0;
            tmo           <= 24'd0;
            tmo_cfg       <= 24'd0;
            req           <= 4'd0;
            det_q         <= 1'b0;
            SYNC_FOUND    <= 1'b0;
            SYNC_WORD_OUT <= 16'd0;
            MASK_OUT      <= 16'd0;
        end else begin
            state       <= state_n;
            MATCH_COUNT <= cnt_n;
            gap         <= gap_n;
            SYNC_FOUND  <= (state_n == S_FOUND) && (state != S_FOUND);
            if (arm) begin
                SYNC_WORD_OUT <= SYNC_WORD_CFG;
                MASK_OUT      <= MASK_CFG;
                req           <= (SYNC_COUNT_CFG == 4'd0) ? 4'd1 : SYNC_COUNT_CFG;
                tmo_cfg       <= TIMEOUT_CFG;
                tmo           <= 24'd0;
                // a detection already asserted at arm time must not count
                det_q         <= 1'b1;
            end else begin
                if (CLKEN) det_q <= SYNC_WORD_DETECTED;
                if (CLKEN && busy_s) tmo <= tmo_inc;
            end
        end
    end

    assign BUSY      = busy_s;
    assign DONE      = (state == S_FOUND);
    assign TIMED_OUT = (state == S_TIMEOUT);

endmodule

// File: doc/mfm_sync_sequencer.md
Name: mfm_sync_sequencer

Overview:
- Arms, configures and supervises the MFM sync-word detector during address-mark and data-mark acquisition.
- Drives the sync word and mask into the detector and watches its SYNC_WORD_DETECTED output.
- Requires N correctly spaced consecutive detections, for example the three A1* marks. It then reports a match, a timeout, or an abort to the acquisition engine.
- Sits between the host-register block and the detector, in the data-separator clock domain.

Parameters:
SPACING_MIN, 16'd496, minimum CLKEN ticks between consecutive detection edges (16 MFM cells at 32 ticks/cell, -16).
SPACING_MAX, 16'd528, maximum CLKEN ticks between consecutive detection edges (+16).

Ports:
MASTER_CLK  in  1  master clock; all logic on its rising edge.
RESET  in  1  synchronous reset, active-high.
CLKEN  in  1  data-separator clock enable; the same enable that feeds the detector.
START  in  1  one-cycle arm pulse; ignored unless state is IDLE, FOUND or TIMEOUT.
ABORT  in  1  one-cycle abort pulse.
SYNC_WORD_CFG  in  16  sync word latched on START.
MASK_CFG  in  16  mask latched on START.
SYNC_COUNT_CFG  in  4  required consecutive detections, latched on START; 0 is treated as 1.
TIMEOUT_CFG  in  24  CLKEN ticks allowed from arm to final match, latched on START; 0 means no timeout.
SYNC_WORD_DETECTED  in  1  level from the detector, updated on CLKEN.
SYNC_WORD_OUT  out  16  to the detector.
MASK_OUT  out  16  to the detector.
BUSY  out  1  high in ARMED or TRACK.
SYNC_FOUND  out  1  one-cycle pulse on the final match.
DONE  out  1  sticky; high in FOUND.
TIMED_OUT  out  1  sticky; high in TIMEOUT.
MATCH_COUNT  out  4  detections accepted in the current run.

Behaviour:
- Reset values: all outputs 0; SYNC_WORD_OUT=0; MASK_OUT=0 (the detector then matches trivially, but BUSY=0 so the match is ignored); state IDLE; all counters 0.
- Reset in any state returns to IDLE in the same edge and overrides START and ABORT.
- Detection event (det_ev): registered copy det_q updates only on CLKEN; det_ev = CLKEN & SYNC_WORD_DETECTED & ~det_q. A level held high counts as a single event.
- States:
  - IDLE: wait for START.
  - START (valid in IDLE, FOUND or TIMEOUT): latch config into SYNC_WORD_OUT/MASK_OUT and internal registers; clear MATCH_COUNT, DONE, TIMED_OUT, gap counter and timeout counter; set det_q=1 so a detection already in progress is not counted; go to ARMED.
  - START in ARMED or TRACK: ignored.
  - ARMED: on det_ev, MATCH_COUNT=1 and gap=0. If the required count is 1, go to FOUND; otherwise go to TRACK.
  - TRACK: gap increments on every CLKEN, saturating at 16'hFFFF.
    - gap > SPACING_MAX with no event: MATCH_COUNT=0, return to ARMED.
    - det_ev with gap in [SPACING_MIN, SPACING_MAX]: MATCH_COUNT+1, gap=0. If the new count equals the required count, go to FOUND.
    - det_ev outside the window: restart the run; MATCH_COUNT=1, gap=0, stay in TRACK. If the required count is 1, this case cannot occur.
  - FOUND: SYNC_FOUND pulses exactly one cycle, on the edge after the accepting det_ev. DONE=1. SYNC_WORD_OUT/MASK_OUT hold their values. Wait for START.
  - TIMEOUT: TIMED_OUT=1, MATCH_COUNT holds its last value, wait for START.
- Timeout counter: increments on CLKEN in ARMED and TRACK. When TIMEOUT_CFG≠0 and the counter reaches TIMEOUT_CFG, go to TIMEOUT.
- Simultaneous final det_ev and timeout on the same CLKEN: the match wins (FOUND).
- ABORT in ARMED or TRACK: go to IDLE; MATCH_COUNT=0, DONE=0, TIMED_OUT=0, no SYNC_FOUND.
- ABORT in other states: no effect.
- Simultaneous ABORT and det_ev: ABORT wins.
- Outputs are registered, with no combinational path from input to output.

Test Plan:
- Reset then idle: assert RESET for 3 cycles mid-TRACK (MATCH_COUNT=2) → all outputs 0, state IDLE; SYNC_WORD_DETECTED pulses while idle → no SYNC_FOUND.
- Triple A1: START with SYNC_WORD_CFG=16'h4489, MASK_CFG=16'hFFFF, SYNC_COUNT_CFG=3, TIMEOUT_CFG=0; detector edges at ticks 100, 612, 1124 → SYNC_OUT=4489, MATCH_COUNT 1,2,3; SYNC_FOUND one cycle after the tick-1124 edge; DONE=1, BUSY=0.
- Spacing violation: SYNC_COUNT_CFG=2; edges at 100, 400, 912 → 400 restarts the count at 1, 912 (gap 512) gives count 2 and SYNC_FOUND. Separately, a single edge then silence for 529 ticks → MATCH_COUNT back to 0, ARMED.
- Held level: SYNC_WORD_DETECTED held high for 40 ticks → MATCH_COUNT increments once only. A detection high at START → not counted.
- Timeout: TIMEOUT_CFG=1000, no edges → TIMED_OUT=1 after exactly 1000 CLKENs. Final edge coincident with tick 1000 → DONE=1, TIMED_OUT=0. Re-START from TIMEOUT clears TIMED_OUT.
- Abort: ABORT in TRACK at MATCH_COUNT=2 → IDLE with MATCH_COUNT=0. ABORT on the same cycle as the accepting det_ev → no SYNC_FOUND. START while BUSY → ignored, config unchanged.
